// File: rtl/io_uart_fifo.sv
`default_nettype none
// ============================================================================
// Module   : io_uart_fifo
// Purpose  : Memory-mapped I/O peripheral with a LED register and an 8N1 UART
//            transmitter fed by a TX FIFO. It has a programmable baud divisor
//            and a status register that reports the FIFO level and a sticky
//            overflow flag.
// Ports    : clk_i          - system clock, rising edge
//            reset_i        - asynchronous active-high reset
//            IO_memAddr_i   - byte address, one-hot register select in [5:2]
//            IO_memRData_o  - combinational read data
//            IO_memWData_i  - write data
//            IO_memWr_i     - single-cycle write strobe
//            leds_o         - LED register
//            txd_o          - UART serial output, idle high
// Register map (word-address bit -> register):
//            bit0 LEDS (R/W), bit1 UART_DAT (W), bit2 UART_CTRL (R/W),
//            bit3 BAUD (R/W)
// Revision : 1.0 - initial release
// ============================================================================
module io_uart_fifo #(
  parameter int LED_WIDTH  = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_RESET  = 868
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [31:0]          IO_memAddr_i,
  output logic [31:0]          IO_memRData_o,
  input  logic [31:0]          IO_memWData_i,
  input  logic                 IO_memWr_i,
  output logic [LED_WIDTH-1:0] leds_o,
  output logic                 txd_o
);

  localparam int          c_AW      = $clog2(FIFO_DEPTH);
  localparam int          c_CW      = c_AW + 1;
  localparam logic [15:0] c_DIV_MIN = 16'd4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_t;

  // --------------------------------------------------------------------------
  // Register select
  // --------------------------------------------------------------------------
  logic w_sel_leds, w_sel_dat, w_sel_ctrl, w_sel_baud;
  logic w_unused_bits;

  assign w_sel_leds = IO_memAddr_i[2];
  assign w_sel_dat  = IO_memAddr_i[3];
  assign w_sel_ctrl = IO_memAddr_i[4];
  assign w_sel_baud = IO_memAddr_i[5];

  // Address and data bits that no register decodes.
  assign w_unused_bits = ^{IO_memAddr_i, IO_memWData_i};

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [LED_WIDTH-1:0] r_leds;
  logic [15:0]          r_div;
  logic                 r_ovf;
  logic [7:0]           r_mem [FIFO_DEPTH];
  logic [c_AW-1:0]      r_wr_ptr, r_rd_ptr;
  logic [c_CW-1:0]      r_count;

  tx_state_t            r_state, w_state_next;
  logic [15:0]          r_div_cnt;
  logic [15:0]          r_frame_div;
  logic [2:0]           r_bit_idx;
  logic [7:0]           r_shift;

  logic w_empty, w_full, w_active;
  logic w_dat_wr, w_push, w_pop, w_ovf_set, w_ovf_clr;
  logic w_bit_end, w_txd;
  logic [15:0] w_baud_val;

  assign w_empty   = (r_count == '0);
  // Full is judged on the count before the edge; a pop on the same edge
  // does not free a slot for the incoming byte.
  assign w_full    = (r_count == c_CW'(FIFO_DEPTH));
  assign w_active  = (r_state != S_IDLE);

  assign w_dat_wr  = IO_memWr_i & w_sel_dat;
  assign w_push    = w_dat_wr & ~w_full;
  assign w_ovf_set = w_dat_wr &  w_full;
  assign w_ovf_clr = IO_memWr_i & w_sel_ctrl & IO_memWData_i[3];

  assign w_baud_val = (IO_memWData_i[15:0] < c_DIV_MIN) ? c_DIV_MIN
                                                         : IO_memWData_i[15:0];

  assign w_bit_end = (r_div_cnt == (r_frame_div - 16'd1));

  // --------------------------------------------------------------------------
  // Software-visible registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_leds <= '0;
      r_div  <= 16'(DIV_RESET);
      r_ovf  <= 1'b0;
    end else begin
      if (IO_memWr_i && w_sel_leds) r_leds <= IO_memWData_i[LED_WIDTH-1:0];
      if (IO_memWr_i && w_sel_baud) r_div  <= w_baud_val;
      // A dropped byte on the same edge as a clear keeps the flag set.
      if (w_ovf_set)      r_ovf <= 1'b1;
      else if (w_ovf_clr) r_ovf <= 1'b0;
    end
  end

  assign leds_o = r_leds;

  // --------------------------------------------------------------------------
  // TX FIFO
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= IO_memWData_i[7:0];
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // TX FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_txd        = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_state_next = S_START;
        end
      end
      S_START: begin
        w_txd = 1'b0;
        if (w_bit_end) w_state_next = S_DATA;
      end
      S_DATA: begin
        w_txd = r_shift[0];
        if (w_bit_end && (r_bit_idx == 3'd7)) w_state_next = S_STOP;
      end
      S_STOP: begin
        // Back-to-back frames: the next byte starts without an idle bit.
        if (w_bit_end) begin
          if (!w_empty) begin
            w_pop        = 1'b1;
            w_state_next = S_START;
          end else begin
            w_state_next = S_IDLE;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Frame datapath. The divisor is captured at frame start so that a BAUD
  // write mid-frame only affects the following frame.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_div_cnt   <= '0;
      r_frame_div <= 16'(DIV_RESET);
      r_bit_idx   <= '0;
      r_shift     <= '0;
    end else if (w_pop) begin
      r_shift     <= r_mem[r_rd_ptr];
      r_frame_div <= r_div;
      r_div_cnt   <= '0;
      r_bit_idx   <= '0;
    end else if (r_state != S_IDLE) begin
      if (w_bit_end) begin
        r_div_cnt <= '0;
        if (r_state == S_DATA) begin
          r_shift   <= {1'b0, r_shift[7:1]};
          r_bit_idx <= r_bit_idx + 3'd1;
        end
      end else begin
        r_div_cnt <= r_div_cnt + 16'd1;
      end
    end
  end

  assign txd_o = w_txd;

  // --------------------------------------------------------------------------
  // Read mux: lowest selected bit wins; UART_DAT is write-only.
  // --------------------------------------------------------------------------
  always_comb begin
    IO_memRData_o = 32'd0;
    if (w_sel_leds) begin
      IO_memRData_o = 32'(r_leds);
    end else if (w_sel_dat) begin
      IO_memRData_o = 32'd0;
    end else if (w_sel_ctrl) begin
      IO_memRData_o = {8'd0, 8'(r_count), 6'd0, w_full, 5'd0,
                       r_ovf, w_full, w_empty, w_active};
    end else if (w_sel_baud) begin
      IO_memRData_o = {16'd0, r_div};
    end
  end

`ifdef BENCH
  always @(posedge clk_i) begin
    if (w_push) begin
      $write("%c", IO_memWData_i[7:0]);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_io_uart_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_io_uart_fifo
// Purpose  : Directed bench for io_uart_fifo. Bytes pushed to the FIFO are
//            queued with their expected bit length; a line monitor decodes
//            txd_o, checks every bit period and the byte value, and records
//            the cycle each frame starts.
// Revision : 1.0 - initial release
// ============================================================================
module tb_io_uart_fifo;

  localparam logic [31:0] c_A_LEDS = 32'h0000_0004;
  localparam logic [31:0] c_A_DAT  = 32'h0000_0008;
  localparam logic [31:0] c_A_CTRL = 32'h0000_0010;
  localparam logic [31:0] c_A_BAUD = 32'h0000_0020;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b0;
  logic [31:0] IO_memAddr_i = '0;
  logic [31:0] IO_memRData_o;
  logic [31:0] IO_memWData_i = '0;
  logic        IO_memWr_i = 1'b0;
  logic [15:0] leds_o;
  logic        txd_o;

  io_uart_fifo dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .IO_memAddr_i  (IO_memAddr_i),
    .IO_memRData_o (IO_memRData_o),
    .IO_memWData_i (IO_memWData_i),
    .IO_memWr_i    (IO_memWr_i),
    .leds_o        (leds_o),
    .txd_o         (txd_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0] data;
    int         div;
  } sb_t;

  sb_t sb[$];
  int  start_q[$];
  bit  mon_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    IO_memAddr_i  = a;
    IO_memWData_i = d;
    IO_memWr_i    = 1'b1;
    tick();
    IO_memWr_i    = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    IO_memAddr_i = a;
    #1;
    d = IO_memRData_o;
  endtask

  task automatic check_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] v;
    rd(a, v);
    check(tag, v, exp);
  endtask

  task automatic push(input logic [7:0] b, input int div);
    sb_t e;
    e.data = b;
    e.div  = div;
    sb.push_back(e);
    wr(c_A_DAT, {24'd0, b});
  endtask

  task automatic wait_idle(input string tag, input int budget);
    logic [31:0] v;
    int n;
    n = 0;
    while (n < budget) begin
      rd(c_A_CTRL, v);
      if (v[1:0] == 2'b10) break;
      tick();
      n++;
    end
    check(tag, 32'(n < budget), 32'd1);
  endtask

  task automatic check_start(input string tag, input int exp);
    check({tag, "_seen"}, 32'(start_q.size() > 0), 32'd1);
    if (start_q.size() > 0) check(tag, start_q.pop_front(), exp);
  endtask

  // --------------------------------------------------------------------------
  // Line monitor: samples txd_o on falling clock edges.
  // --------------------------------------------------------------------------
  sb_t        m_e;
  logic [9:0] m_rx;
  int         m_bad;
  bit         m_abort;
  int         m_frames = 0;

  initial begin
    forever begin
      @(negedge clk_i);
      if (mon_en && txd_o === 1'b0) begin
        check("sb_nonempty_at_start", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          m_e = sb.pop_front();
          start_q.push_back(cyc);
          m_abort = 1'b0;
          m_rx    = '0;
          for (int slot = 0; slot < 10; slot++) begin
            logic exp_lvl;
            exp_lvl = (slot == 0) ? 1'b0 : (slot == 9) ? 1'b1 : m_e.data[slot-1];
            m_bad = 0;
            for (int s = 0; s < m_e.div; s++) begin
              if (!m_abort) begin
                if (!(slot == 0 && s == 0)) @(negedge clk_i);
                if (!mon_en) m_abort = 1'b1;
                else begin
                  if (txd_o !== exp_lvl) m_bad++;
                  if (s == m_e.div / 2) m_rx[slot] = txd_o;
                end
              end
            end
            if (!m_abort)
              check($sformatf("frame%0d_slot%0d_bad_samples", m_frames, slot), m_bad, 0);
          end
          if (!m_abort) begin
            check($sformatf("frame%0d_byte", m_frames), {24'd0, m_rx[8:1]}, {24'd0, m_e.data});
            m_frames++;
          end
        end
      end
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  // --------------------------------------------------------------------------
  // Directed sequence
  // --------------------------------------------------------------------------
  initial begin
    int c0;

    // Reset asserted between clock edges: outputs must settle with no edge.
    #2 reset_i = 1'b1;
    #1;
    check("rst_async_txd", {31'd0, txd_o}, 32'd1);
    check("rst_async_leds", {16'd0, leds_o}, 32'd0);
    repeat (3) @(posedge clk_i);
    #3 reset_i = 1'b0;
    tick();
    check_rd("rst_ctrl", c_A_CTRL, 32'h0000_0002);
    check_rd("rst_baud", c_A_BAUD, 32'd868);
    mon_en = 1'b1;

    // LED register, read priority, multi-select write
    wr(c_A_LEDS, 32'hFFFF_A5C3);
    check("led_out", {16'd0, leds_o}, 32'h0000_A5C3);
    check_rd("led_rd", c_A_LEDS, 32'h0000_A5C3);
    check_rd("prio_leds_ctrl", c_A_LEDS | c_A_CTRL, 32'h0000_A5C3);
    check_rd("prio_ctrl_baud", c_A_CTRL | c_A_BAUD, 32'h0000_0002);
    check_rd("no_select", 32'h0000_0000, 32'd0);
    wr(c_A_LEDS | c_A_BAUD, 32'h0000_0005);
    check("multi_wr_leds", {16'd0, leds_o}, 32'd5);
    check_rd("multi_wr_baud", c_A_BAUD, 32'd5);

    // BAUD: upper half ignored, small values clamped to 4
    wr(c_A_BAUD, 32'hABCD_0007);
    check_rd("baud_upper_ignored", c_A_BAUD, 32'd7);
    wr(c_A_BAUD, 32'd1);
    check_rd("baud_clamp", c_A_BAUD, 32'd4);

    // Single byte 0x55 at div 4
    push(8'h55, 4);
    c0 = cyc;
    check_rd("single_ctrl_after_push", c_A_CTRL, 32'h0001_0000);
    while (cyc < c0 + 40) tick();
    check_rd("single_active_last", c_A_CTRL, 32'h0000_0003);
    tick();
    check_rd("single_idle_after_40", c_A_CTRL, 32'h0000_0002);
    check_start("single_start_cyc", c0 + 1);

    // Burst of three bytes. The first pop lands on the second push's edge,
    // so the level reads 1, 1, 2 before draining.
    push(8'h41, 4);
    c0 = cyc;
    check_rd("burst_ctrl1", c_A_CTRL, 32'h0001_0000);
    push(8'h42, 4);
    check_rd("burst_ctrl2", c_A_CTRL, 32'h0001_0001);
    push(8'h43, 4);
    check_rd("burst_ctrl3", c_A_CTRL, 32'h0002_0001);
    while (cyc < c0 + 42) tick();
    check_rd("burst_drain", c_A_CTRL, 32'h0001_0001);
    wait_idle("burst_idle", 300);
    check_start("burst_start0", c0 + 1);
    check_start("burst_start1", c0 + 41);
    check_start("burst_start2", c0 + 81);
    check("burst_sb_empty", sb.size(), 0);

    // Overflow: 18 pushes one per cycle at div 868; the 18th is dropped.
    wr(c_A_BAUD, 32'd868);
    c0 = cyc + 1;
    for (int i = 0; i < 18; i++) begin
      if (i < 17) push(8'(8'h60 + i), (i == 0) ? 868 : 4);
      else        wr(c_A_DAT, 32'h0000_0071);
    end
    check_rd("ovf_ctrl", c_A_CTRL, 32'h0010_020D);
    // Dropped push and clear on the same edge: the set wins.
    wr(c_A_DAT | c_A_CTRL, 32'h0000_0008);
    check_rd("ovf_set_beats_clear", c_A_CTRL, 32'h0010_020D);
    wr(c_A_CTRL, 32'h0000_0008);
    check_rd("ovf_cleared", c_A_CTRL, 32'h0010_0205);
    // Shorter bits from the second frame keep the run short.
    wr(c_A_BAUD, 32'd4);
    wait_idle("ovf_idle", 12000);
    check_start("ovf_first_pop", c0 + 1);
    check("ovf_frames", start_q.size(), 16);
    start_q.delete();
    check("ovf_sb_empty", sb.size(), 0);

    // Divisor change mid-frame
    wr(c_A_BAUD, 32'd6);
    push(8'hA3, 6);
    c0 = cyc;
    push(8'h5C, 4);
    repeat (20) tick();
    wr(c_A_BAUD, 32'd3);
    check_rd("div_change_baud", c_A_BAUD, 32'd4);
    wait_idle("div_idle", 400);
    check_start("div_start0", c0 + 1);
    check_start("div_start1", c0 + 61);
    check("div_sb_empty", sb.size(), 0);

    // Reset mid-frame: line idles at once, FIFO discarded
    wr(c_A_LEDS, 32'h0000_1234);
    push(8'h11, 4);
    push(8'h22, 4);
    push(8'h33, 4);
    repeat (10) tick();
    check("pre_reset_txd_low_ok", {31'd0, txd_o}, {31'd0, sb[0].data[0]});
    mon_en = 1'b0;
    #3 reset_i = 1'b1;
    #1;
    check("midrst_txd", {31'd0, txd_o}, 32'd1);
    check("midrst_leds", {16'd0, leds_o}, 32'd0);
    check_rd("midrst_ctrl", c_A_CTRL, 32'h0000_0002);
    check_rd("midrst_baud", c_A_BAUD, 32'd868);
    tick();
    reset_i = 1'b0;
    sb.delete();
    start_q.delete();
    mon_en = 1'b1;
    repeat (60) tick();
    check("postrst_no_frames", start_q.size(), 0);
    check("postrst_txd", {31'd0, txd_o}, 32'd1);
    check_rd("postrst_ctrl", c_A_CTRL, 32'h0000_0002);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
